pixel_out_buffer: RTL and testbench
===================================

# pixel_out_buffer

Downstream stage of the chromatic-adaptation image processor. It captures every adapted pixel the processor emits, which arrive on a valid strobe with no backpressure. It tags each pixel with frame position markers (start of frame, end of line, end of frame) and buffers it in a small FIFO. It then re-presents the pixels on a valid/ready stream to the display/memory writer, and raises a hold-off signal so the processor's input side can be throttled before the FIFO overflows.

## Interface
- `ADDR_BITS`, 4: FIFO depth = 2^ADDR_BITS entries (16).
- `IMG_WIDTH`, 640: pixels per line.
- `IMG_HEIGHT`, 480: lines per frame.
- `COORD_BITS`, 12: width of the column and row counters; must hold IMG_WIDTH-1 and IMG_HEIGHT-1.
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_rgb`  in  24: adapted pixel {R,G,B}, 8 bits per channel; driven by the processor's `output_rgb`.
- `in_valid`  in  1: pixel strobe; driven by the processor's `output_valid`. Never stalled.
- `frame_start`  in  1: one-cycle pulse; resets the column and row counters to (0,0).
- `clr_status`  in  1: one-cycle pulse; clears `overflow` and `drop_count`.
- `out_rgb`  out  24: head-of-FIFO pixel; 0 while `out_valid`=0.
- `out_sof`, `out_eol`, `out_eof`  out  1 each: head-entry tags; 0 while `out_valid`=0.
- `out_valid`  out  1: FIFO non-empty.
- `out_ready`  in  1: consumer accepts the head entry.
- `level`  out  ADDR_BITS+1: number of occupied entries.
- `hold_off`  out  1: `level` >= 2^ADDR_BITS − 2; gates the processor's `input_valid` upstream.
- `overflow`  out  1: sticky; set when any pixel is dropped.
- `drop_count`  out  16: number of dropped pixels; saturates at 0xFFFF.
- `frame_done`  out  1: one-cycle pulse when an EOF-tagged entry is consumed.

## Operation
- **Storage.** 27-bit entries {eof, eol, sof, rgb[23:0]}. Write pointer and read pointer are ADDR_BITS wide and wrap modulo depth. An occupancy counter drives `level`.
- **Tagging.** At each `in_valid`, the current column/row (col,row) determines the tags:
  - sof = (col==0 && row==0)
  - eol = (col==IMG_WIDTH−1)
  - eof = eol && (row==IMG_HEIGHT−1)
- **Counter advance.** col increments on every `in_valid`, whether the pixel is written or dropped, so frame geometry stays aligned. At IMG_WIDTH−1, col wraps to 0 and row increments. At the last pixel of the frame, both wrap to 0.
- **Write rule.**
  - Write occurs when `in_valid` && (level < depth, or a read happens in the same cycle).
  - Otherwise the pixel is dropped: `overflow` is set to 1 and `drop_count` increments (saturating).
- **Read rule.** Read occurs on `out_valid` && `out_ready`. The read pointer advances and `frame_done` pulses on the next cycle if the consumed entry has eof=1.
- **Level update.** `level` changes by +1 for a write only, −1 for a read only, and 0 for both or neither.
- **frame_start.**
  - With `in_valid` in the same cycle, the pixel is tagged as (0,0) (sof=1) and the counters go to (1,0).
  - `frame_start` does not flush the FIFO.
- **clr_status.**
  - Clears `overflow` and `drop_count` to 0.
  - If a drop occurs in the same cycle, the drop wins: `overflow`=1 and `drop_count`=1.
- **Output path.** First-word-fall-through: the `out_*` signals are a combinational read of the entry at the read pointer, masked to 0 when empty.
- **Reset.**
  - Pointers, `level`, col and row: 0.
  - `out_valid`, `out_rgb`, all tags, `hold_off`, `overflow`, `drop_count`, `frame_done`: 0.
  - Reset mid-frame discards all buffered entries and counter state.

## Timing
- **Latency.** A pixel written into an empty FIFO at edge N appears with `out_valid`=1 in the cycle after edge N, i.e. one cycle of latency.
- **Throughput.** One write and one read per cycle, sustained.
- **Derived outputs.** `level`, `hold_off` and `overflow` reflect the updates from the preceding edge. `hold_off` asserts in the same cycle `level` reaches depth−2, which leaves 2 entries of slack for pixels already in flight in the processor.
- **frame_done.** Registered; high for exactly one cycle following the consuming edge.
- **Handshake.** `out_rgb` and the tags stay stable while `out_valid`=1 and `out_ready`=0.

## Test plan
- **Reset.** Release `rst_n`, then write 3 pixels 0x112233, 0x445566, 0x778899 with `out_ready`=0. Required: `level`=3 and `out_rgb`=0x112233 with `out_sof`=1. Then hold `out_ready`=1 and check the pixels emerge in order, `out_valid` drops after the 3rd, and `level` returns to 0.
- **Geometry.** With IMG_WIDTH=4, IMG_HEIGHT=2, stream 8 pixels with `out_ready`=1. Required:
  - sof only on pixel 0
  - eol on pixels 3 and 7
  - eof on pixel 7
  - `frame_done` pulses once, the cycle after pixel 7 is consumed
  - pixel 8 carries sof=1 again
- **Overflow.** Depth 16, `out_ready`=0, write 18 pixels. Required:
  - `hold_off`=1 once `level`=14
  - `level` stops at 16
  - `overflow`=1 and `drop_count`=2
  - tag positions of later pixels stay aligned (the dropped pixels still advanced col)
- **Full with simultaneous read and write.** At `level`=16, assert `in_valid` and `out_ready` together. Required: no drop, `level` stays 16, and the new pixel lands at the tail.
- **frame_start during a pixel.** Mid-line at col 2, pulse `frame_start` together with `in_valid`. Required: that pixel has sof=1 and the next pixel has col=1 (no sof). A same-cycle `clr_status` and drop yields `drop_count`=1.
- **Mid-operation reset.** Assert `rst_n`=0 with `level`=5. Required: all outputs go to 0 immediately, and after release the first pixel has sof=1.

Source files
------------

// File: rtl/pixel_out_buffer.sv
// Output buffer for the chromatic-adaptation pipeline: tags pixels with
// frame markers, queues them in a FWFT FIFO and re-presents them valid/ready.
module pixel_out_buffer #(
    parameter int ADDR_BITS  = 4,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int COORD_BITS = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [23:0]          in_rgb,
    input  logic                 in_valid,
    input  logic                 frame_start,
    input  logic                 clr_status,
    output logic [23:0]          out_rgb,
    output logic                 out_sof,
    output logic                 out_eol,
    output logic                 out_eof,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADDR_BITS:0]   level,
    output logic                 hold_off,
    output logic                 overflow,
    output logic [15:0]          drop_count,
    output logic                 frame_done
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] LVL_FULL = (ADDR_BITS+1)'(DEPTH);
    localparam logic [ADDR_BITS:0] LVL_HOLD = (ADDR_BITS+1)'(DEPTH - 2);
    localparam logic [ADDR_BITS:0] LVL_ONE  = (ADDR_BITS+1)'(1);
    localparam logic [ADDR_BITS-1:0] PTR_ONE = ADDR_BITS'(1);
    localparam logic [COORD_BITS-1:0] COL_LAST = COORD_BITS'(IMG_WIDTH - 1);
    localparam logic [COORD_BITS-1:0] ROW_LAST = COORD_BITS'(IMG_HEIGHT - 1);
    localparam logic [COORD_BITS-1:0] CRD_ONE  = COORD_BITS'(1);

    logic [26:0]           mem_q [DEPTH];
    logic [ADDR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]    level_q, level_d;
    logic [COORD_BITS-1:0] col_q, col_d;
    logic [COORD_BITS-1:0] row_q, row_d;
    logic                  overflow_q, overflow_d;
    logic [15:0]           drop_q, drop_d;
    logic                  frame_done_q, frame_done_d;

    logic                  empty;
    logic                  rd_en;
    logic                  wr_en;
    logic                  drop;
    logic [26:0]           head;
    logic [26:0]           wr_entry;
    logic [COORD_BITS-1:0] col_cur;
    logic [COORD_BITS-1:0] row_cur;
    logic                  tag_sof;
    logic                  tag_eol;
    logic                  tag_eof;

    assign empty = (level_q == '0);
    assign head  = mem_q[rd_ptr_q];
    assign rd_en = !empty && out_ready;
    // A full FIFO still accepts a pixel when the head leaves in the same cycle.
    assign wr_en = in_valid && ((level_q != LVL_FULL) || rd_en);
    assign drop  = in_valid && !wr_en;

    // frame_start retargets the current pixel to (0,0) before tagging.
    assign col_cur = frame_start ? '0 : col_q;
    assign row_cur = frame_start ? '0 : row_q;

    assign tag_sof  = (col_cur == '0) && (row_cur == '0);
    assign tag_eol  = (col_cur == COL_LAST);
    assign tag_eof  = tag_eol && (row_cur == ROW_LAST);
    assign wr_entry = {tag_eof, tag_eol, tag_sof, in_rgb};

    always_comb begin
        col_d = col_cur;
        row_d = row_cur;
        if (in_valid) begin
            if (tag_eol) begin
                col_d = '0;
                row_d = (row_cur == ROW_LAST) ? '0 : row_cur + CRD_ONE;
            end else begin
                col_d = col_cur + CRD_ONE;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        unique case ({wr_en, rd_en})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // A drop in the same cycle as a clear leaves the drop recorded.
    always_comb begin
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (clr_status) begin
            overflow_d = 1'b0;
            drop_d     = '0;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_status) begin
                drop_d = 16'd1;
            end else if (drop_q != 16'hFFFF) begin
                drop_d = drop_q + 16'd1;
            end
        end
    end

    assign frame_done_d = rd_en && head[26];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            col_q        <= '0;
            row_q        <= '0;
            overflow_q   <= 1'b0;
            drop_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            col_q        <= col_d;
            row_q        <= row_d;
            overflow_q   <= overflow_d;
            drop_q       <= drop_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_valid  = !empty;
    assign out_rgb    = empty ? 24'd0 : head[23:0];
    assign out_sof    = !empty && head[24];
    assign out_eol    = !empty && head[25];
    assign out_eof    = !empty && head[26];
    assign level      = level_q;
    assign hold_off   = (level_q >= LVL_HOLD);
    assign overflow   = overflow_q;
    assign drop_count = drop_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_out_buffer.sv
// Bench for pixel_out_buffer on a 4x2 frame with a 16-entry FIFO: a queue
// model checked every cycle plus literal spot checks along directed vectors.
module tb_pixel_out_buffer;

    localparam int W     = 4;
    localparam int H     = 2;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [23:0] in_rgb = '0;
    logic        in_valid = 1'b0;
    logic        frame_start = 1'b0;
    logic        clr_status = 1'b0;
    logic [23:0] out_rgb;
    logic        out_sof;
    logic        out_eol;
    logic        out_eof;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  level;
    logic        hold_off;
    logic        overflow;
    logic [15:0] drop_count;
    logic        frame_done;

    pixel_out_buffer #(
        .ADDR_BITS(4),
        .IMG_WIDTH(W),
        .IMG_HEIGHT(H),
        .COORD_BITS(12)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_rgb(in_rgb),
        .in_valid(in_valid),
        .frame_start(frame_start),
        .clr_status(clr_status),
        .out_rgb(out_rgb),
        .out_sof(out_sof),
        .out_eol(out_eol),
        .out_eof(out_eof),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .level(level),
        .hold_off(hold_off),
        .overflow(overflow),
        .drop_count(drop_count),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model: queue of tagged entries and plain frame coordinates.
    logic [26:0] mq[$];
    int          m_col = 0;
    int          m_row = 0;
    bit          m_ovf = 0;
    int          m_drops = 0;
    bit          m_fd = 0;
    int          m_c;
    int          m_r;
    bit          m_rd;
    bit          m_wr;
    logic [26:0] m_e;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_col = 0;
            m_row = 0;
            m_ovf = 0;
            m_drops = 0;
            m_fd = 0;
        end else begin
            m_rd = (mq.size() > 0) && out_ready;
            m_fd = m_rd && mq[0][26];
            m_c = frame_start ? 0 : m_col;
            m_r = frame_start ? 0 : m_row;
            m_wr = 0;
            if (in_valid) begin
                m_e = {(m_c == W-1 && m_r == H-1), (m_c == W-1),
                       (m_c == 0 && m_r == 0), in_rgb};
                m_wr = (mq.size() < DEPTH) || m_rd;
            end
            if (m_rd) void'(mq.pop_front());
            if (m_wr) mq.push_back(m_e);
            if (in_valid) begin
                m_c = m_c + 1;
                if (m_c == W) begin
                    m_c = 0;
                    m_r = (m_r + 1) % H;
                end
            end
            m_col = m_c;
            m_row = m_r;
            if (clr_status) begin
                m_ovf = 0;
                m_drops = 0;
            end
            if (in_valid && !m_wr) begin
                m_ovf = 1;
                if (m_drops < 65535) m_drops++;
            end
        end
    end

    logic [26:0] cmp_h;
    always @(negedge clk) begin
        if (chk_en) begin
            cmp_h = (mq.size() > 0) ? mq[0] : 27'd0;
            chk("m_valid", out_valid, mq.size() > 0);
            chk("m_rgb", out_rgb, cmp_h[23:0]);
            chk("m_sof", out_sof, cmp_h[24]);
            chk("m_eol", out_eol, cmp_h[25]);
            chk("m_eof", out_eof, cmp_h[26]);
            chk("m_level", level, mq.size());
            chk("m_hold", hold_off, mq.size() >= DEPTH - 2);
            chk("m_ovf", overflow, m_ovf);
            chk("m_drops", drop_count, m_drops);
            chk("m_fdone", frame_done, m_fd);
        end
    end

    task automatic step(input logic v, input logic [23:0] rgb,
                        input logic rdy, input logic fs, input logic clr);
        in_valid    = v;
        in_rgb      = rgb;
        out_ready   = rdy;
        frame_start = fs;
        clr_status  = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", out_valid, 0);
        chk("reset_level", level, 0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // fill three, then drain in order
        step(1, 24'h112233, 0, 0, 0);
        step(1, 24'h445566, 0, 0, 0);
        step(1, 24'h778899, 0, 0, 0);
        chk("rst_level3", level, 3);
        chk("rst_head", out_rgb, 24'h112233);
        chk("rst_sof", out_sof, 1);
        step(0, 0, 1, 0, 0);
        chk("ord1", out_rgb, 24'h445566);
        step(0, 0, 1, 0, 0);
        chk("ord2", out_rgb, 24'h778899);
        step(0, 0, 1, 0, 0);
        chk("ord_empty", out_valid, 0);
        chk("ord_level0", level, 0);

        // geometry: one full 4x2 frame plus the next frame's first pixel
        step(0, 0, 1, 1, 0);
        for (int i = 0; i < 9; i++) begin
            step(1, 24'hA0 + 24'(i), 1, 0, 0);
            chk("geo_rgb", out_rgb, 24'hA0 + 24'(i));
            chk("geo_sof", out_sof, (i == 0 || i == 8));
            chk("geo_eol", out_eol, (i == 3 || i == 7));
            chk("geo_eof", out_eof, (i == 7));
            chk("geo_fdone", frame_done, (i == 8));
        end
        step(0, 0, 1, 0, 0);
        chk("geo_fdone_end", frame_done, 0);

        // overflow: 18 writes into 16 entries
        step(0, 0, 1, 1, 0);
        for (int i = 0; i < 18; i++) begin
            step(1, 24'hB0 + 24'(i), 0, 0, 0);
            chk("ovf_hold", hold_off, (i >= 13));
            chk("ovf_level", level, (i < 16) ? i + 1 : 16);
        end
        chk("ovf_flag", overflow, 1);
        chk("ovf_drops", drop_count, 2);

        // full with read and write together
        step(1, 24'hC2, 1, 0, 0);
        step(1, 24'hC3, 1, 0, 0);
        chk("rw_level", level, 16);
        chk("rw_drops", drop_count, 2);
        chk("rw_head", out_rgb, 24'hB2);
        for (int i = 0; i < 15; i++) step(0, 0, 1, 0, 0);
        chk("tail_rgb", out_rgb, 24'hC3);
        chk("tail_eol", out_eol, 1);
        chk("tail_sof", out_sof, 0);
        step(0, 0, 1, 0, 0);
        chk("tail_empty", out_valid, 0);

        // frame_start together with a mid-line pixel
        step(1, 24'hD0, 1, 0, 0);
        step(1, 24'hD1, 1, 0, 0);
        step(1, 24'hD2, 1, 1, 0);
        chk("fs_rgb", out_rgb, 24'hD2);
        chk("fs_sof", out_sof, 1);
        step(1, 24'hD3, 1, 0, 0);
        chk("fs_next_rgb", out_rgb, 24'hD3);
        chk("fs_next_sof", out_sof, 0);
        step(0, 0, 1, 0, 0);

        // clear racing a drop
        for (int i = 0; i < 16; i++) step(1, 24'hE0 + 24'(i), 0, 0, 0);
        step(1, 24'hFF, 0, 0, 1);
        chk("clr_drop_ovf", overflow, 1);
        chk("clr_drop_cnt", drop_count, 1);
        step(0, 0, 0, 0, 1);
        chk("clr_ovf", overflow, 0);
        chk("clr_cnt", drop_count, 0);

        // reset with five entries buffered
        for (int i = 0; i < 11; i++) step(0, 0, 1, 0, 0);
        chk("mid_level5", level, 5);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_valid", out_valid, 0);
        chk("mid_level", level, 0);
        chk("mid_rgb", out_rgb, 0);
        chk("mid_hold", hold_off, 0);
        chk("mid_fdone", frame_done, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, 24'h123456, 0, 0, 0);
        chk("post_sof", out_sof, 1);
        chk("post_rgb", out_rgb, 24'h123456);
        chk("post_level", level, 1);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
